// File: rtl/hazard_forward_unit.sv
// Operand-forwarding select generation and stall/flush control for a 5-stage pipeline.
// Forwarding selects are registered so they are stable for the whole EX cycle.
module hazard_forward_unit #(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       ID_Valid,
  input  logic [4:0] ID_rs,
  input  logic [4:0] ID_rt,
  input  logic       ID_UsesRs,
  input  logic       ID_UsesRt,
  input  logic [4:0] EX_destinationReg,
  input  logic       EX_RegWrite,
  input  logic       EX_MemRead,
  input  logic       PCSrc,
  output logic [1:0] A_Mux_sel,
  output logic [1:0] B_Mux_sel,
  output logic       PCWrite,
  output logic       IFID_Write,
  output logic       IDEX_Bubble,
  output logic       IFID_Flush
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [1:0] SEL_REG = 2'b00;
  localparam logic [1:0] SEL_WB  = 2'b01;
  localparam logic [1:0] SEL_MEM = 2'b10;
  localparam logic [1:0] CNT_RELOAD = 2'(FLUSH_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [4:0] mem_dest_q;
  logic       mem_wr_q;
  logic [1:0] a_sel_q, a_sel_d;
  logic [1:0] b_sel_q, b_sel_d;
  logic [1:0] a_next, b_next;
  logic       load_use;

  // EX producer is younger than MEM, so it wins; $0 is hardwired and never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic       uses,
    input logic [4:0] src,
    input logic       ex_wr,
    input logic [4:0] ex_dst,
    input logic       mem_wr,
    input logic [4:0] mem_dst
  );
    logic [1:0] sel;
    sel = SEL_REG;
    if (uses && (src != '0)) begin
      if (ex_wr && (ex_dst == src))
        sel = SEL_MEM;
      else if (mem_wr && (mem_dst == src))
        sel = SEL_WB;
    end
    return sel;
  endfunction

  always_comb begin
    a_next = fwd_sel(ID_UsesRs, ID_rs, EX_RegWrite, EX_destinationReg, mem_wr_q, mem_dest_q);
    b_next = fwd_sel(ID_UsesRt, ID_rt, EX_RegWrite, EX_destinationReg, mem_wr_q, mem_dest_q);
  end

  always_comb begin
    load_use = ID_Valid && EX_MemRead && EX_RegWrite && (EX_destinationReg != '0) &&
               ((ID_UsesRs && (ID_rs == EX_destinationReg)) ||
                (ID_UsesRt && (ID_rt == EX_destinationReg)));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    PCWrite     = 1'b1;
    IFID_Write  = 1'b1;
    IDEX_Bubble = 1'b0;
    IFID_Flush  = 1'b0;
    case (state_q)
      RUN, STALL: begin
        if (PCSrc) begin
          IFID_Flush  = 1'b1;
          IDEX_Bubble = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = CNT_RELOAD;
          end else begin
            state_d = RUN;
          end
        end else if ((state_q == RUN) && load_use) begin
          PCWrite     = 1'b0;
          IFID_Write  = 1'b0;
          IDEX_Bubble = 1'b1;
          state_d     = STALL;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        IFID_Flush  = 1'b1;
        IDEX_Bubble = 1'b1;
        if (PCSrc) begin
          cnt_d = CNT_RELOAD;
        end else if (cnt_q <= 2'd1) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    a_sel_d = IDEX_Bubble ? SEL_REG : a_next;
    b_sel_d = IDEX_Bubble ? SEL_REG : b_next;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      mem_dest_q <= '0;
      mem_wr_q   <= 1'b0;
      a_sel_q    <= '0;
      b_sel_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_dest_q <= EX_destinationReg;
      mem_wr_q   <= EX_RegWrite;
      a_sel_q    <= a_sel_d;
      b_sel_q    <= b_sel_d;
    end
  end

  assign A_Mux_sel = a_sel_q;
  assign B_Mux_sel = b_sel_q;

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Pipeline control block that drives the Execute stage's operand-forwarding selects and the front-end stall/flush controls. It compares the ID-stage instruction's source registers against the destinations of the instructions in EX and MEM, which it tracks internally. It registers `A_Mux_sel`/`B_Mux_sel` so they are valid for the whole cycle the instruction spends in EX. It also inserts a one-cycle load-use bubble and flushes IF/ID after a taken branch or jump resolved in EX.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 1: cycles IF/ID is flushed after a taken branch or jump. Legal range is 1–3.

Ports:
- `Clk`  in  1  single clock; all state updates on rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `ID_Valid`  in  1  the ID-stage slot holds a real instruction.
- `ID_rs`, `ID_rt`  in  5 each  source register numbers of the ID instruction.
- `ID_UsesRs`, `ID_UsesRt`  in  1 each  the ID instruction reads rs / rt.
- `EX_destinationReg`  in  5  destination of the instruction currently in EX.
- `EX_RegWrite`, `EX_MemRead`  in  1 each  the EX instruction writes a register / is a load.
- `PCSrc`  in  1  a taken branch or jump is resolved in EX this cycle.
- `A_Mux_sel`, `B_Mux_sel`  out  2 each  registered forwarding selects for EX. Encoding:
  - 00 = ReadData1 / ReadData2
  - 01 = WriteData_WB
  - 10 = ALUResult_MEM
  - 11 = never driven
- `PCWrite`  out  1  PC may update.
- `IFID_Write`  out  1  the IF/ID register may load.
- `IDEX_Bubble`  out  1  load a NOP into ID/EX.
- `IFID_Flush`  out  1  clear IF/ID to a NOP.

## Operation
Internal tracking:
- The unit holds `MEM_dest`/`MEM_wr`, loaded every cycle from `EX_destinationReg`/`EX_RegWrite`.
- MEM never stalls, so this copy advances unconditionally.

Forwarding decision, evaluated for each source X ∈ {rs, rt} of the ID instruction:
- If `ID_UsesX`, `X != 0`, `EX_RegWrite`, and `EX_destinationReg == X`, then next sel = 10.
- Else if `ID_UsesX`, `X != 0`, `MEM_wr`, and `MEM_dest == X`, then next sel = 01.
- Otherwise next sel = 00.
- The EX match has priority over the MEM match, because it is the younger producer.
- Register $0 never forwards.
- The instruction in WB is not forwarded: the register file writes on the falling edge, so the ID read sees the new value.

Load-use hazard:
- `load_use` is asserted when all of the following hold:
  - `ID_Valid`, `EX_MemRead`, `EX_RegWrite`, and `EX_destinationReg != 0`;
  - `(ID_UsesRs & ID_rs == EX_destinationReg)` or `(ID_UsesRt & ID_rt == EX_destinationReg)`.

State machine, with states RUN, STALL and FLUSH:
- RUN:
  - If `PCSrc` is asserted: `IFID_Flush=1` and `IDEX_Bubble=1`. Go to FLUSH if `FLUSH_CYCLES > 1`, otherwise stay in RUN.
  - Else if `load_use` is asserted: `PCWrite=0`, `IFID_Write=0`, `IDEX_Bubble=1`, and go to STALL.
  - Otherwise all four outputs are at their pass-through values (`PCWrite=1`, `IFID_Write=1`, `IDEX_Bubble=0`, `IFID_Flush=0`).
- STALL: lasts exactly one cycle and outputs pass-through values.
  - The load is now in MEM, so the ID instruction's sel resolves to 01.
  - Return to RUN.
  - If `PCSrc` is asserted in STALL, apply the RUN flush behaviour.
- FLUSH: asserts `IFID_Flush=1` and `IDEX_Bubble=1` for the remaining `FLUSH_CYCLES-1` cycles, counted by a 2-bit down-counter, then returns to RUN.
  - A new `PCSrc` during FLUSH reloads the counter.

Sel register loading:
- When `IDEX_Bubble=1`, the sel registers load 00.
- Otherwise they load the next-sel values computed above.

Priority: flush beats stall. When `PCSrc` and `load_use` occur in the same cycle, there is no stall, `PCWrite=1`, and a bubble is inserted.

## Timing
- All control outputs (`PCWrite`, `IFID_Write`, `IDEX_Bubble`, `IFID_Flush`) are combinational from the current state and inputs, and are valid before the same rising edge.
- `A_Mux_sel`/`B_Mux_sel` update on the rising edge at which the instruction enters EX. They hold for one cycle, giving zero added latency to the datapath.
- `MEM_dest` trails `EX_destinationReg` by exactly one cycle.
- Reset (asynchronous, mid-operation included) forces:
  - state = RUN, counter = 0;
  - `MEM_wr=0`, `MEM_dest=0`;
  - sels = 00;
  - `PCWrite=1`, `IFID_Write=1`, `IDEX_Bubble=0`, `IFID_Flush=0`.
- The first edge after reset release is a normal RUN cycle.
- `ID_Valid=0` suppresses `load_use` but not sel computation; a bubble still loads sels 00.

## Test plan
- Back-to-back dependency: add $3 is in EX with RegWrite, and the ID instruction reads rs=$3. Required: `A_Mux_sel`=10 on the next edge and no stall.
- Distance-2 dependency: $3 is in MEM and the ID instruction reads rt=$3. Required: `B_Mux_sel`=01.
- EX and MEM both write $3 and the ID instruction reads $3. Required: sel=10.
- Load-use: lw $5 is in EX and the ID instruction reads rs=$5. Required:
  - that cycle: `PCWrite=0`, `IFID_Write=0`, `IDEX_Bubble=1`, sels load 00;
  - next cycle: pass-through outputs, `A_Mux_sel` loads 01;
  - exactly one stall cycle.
- $0 destination: EX writes $0 and the ID instruction reads rs=$0. Required: sel=00. lw $0 with a use of $0 causes no stall.
- Flush with `FLUSH_CYCLES=2`: `PCSrc` and `load_use` are both asserted in the same cycle. Required: `IFID_Flush=1` and `IDEX_Bubble=1` for 2 cycles, `PCWrite` stays 1, no STALL. Dropping `Reset_n` mid-flush immediately restores the reset outputs.
